queue: RTL and testbench



---
 rtl/queue.sv | 76 +++++++
 tb/tb_queue.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// queue : single-clock FIFO, registered read port, full/empty from occupancy
// Revision 1.0
// ---------------------------------------------------------------------------
module queue #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enqueue,
  input  logic             dequeue,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam logic [ADDR_WIDTH:0]   C_DEPTH    = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   C_CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE  = ADDR_WIDTH'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic                  wr_en;
  logic                  rd_en;

  assign full  = (count_q == C_DEPTH);
  assign empty = (count_q == '0);

  // A full queue still accepts a write when a read frees the head slot this edge.
  assign wr_en = enqueue & (~full | dequeue);
  assign rd_en = dequeue & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    data_d   = data_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      data_d   = mem_q[rd_ptr_q];
    end
    if (wr_en && !rd_en)      count_d = count_q + C_CNT_ONE;
    else if (rd_en && !wr_en) count_d = count_q - C_CNT_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
    end
  end

  // Storage is not reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out = data_q;

endmodule
`default_nettype wire

// File: tb/tb_queue.sv
`default_nettype none
// tb_queue : directed test-plan sequences plus random traffic against a queue-based model.
module tb_queue;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int ADDR_WIDTH = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enqueue = 1'b0;
  logic             dequeue = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] exp_out = '0;

  queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .enqueue  (enqueue),
    .dequeue  (dequeue),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dout"},  32'(data_out), 32'(exp_out));
    check({tag, ".full"},  32'(full),  32'(model_q.size() == DEPTH));
    check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
  endtask

  // Drive one cycle of inputs, advance the model using pre-edge occupancy, check 1ns after the edge.
  task automatic step(input logic enq, input logic deq, input logic [WIDTH-1:0] din, input string tag);
    bit do_wr, do_rd;
    enqueue = enq;
    dequeue = deq;
    data_in = din;
    do_wr = enq && ((model_q.size() < DEPTH) || deq);
    do_rd = deq && (model_q.size() > 0);
    @(posedge clk);
    if (do_rd) exp_out = model_q.pop_front();
    if (do_wr) model_q.push_back(din);
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset held across a couple of edges
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;
    step(1'b0, 1'b1, 8'h00, "deq_empty_after_reset");

    // Basic FIFO
    step(1'b1, 1'b0, 8'd10, "enq10");
    step(1'b1, 1'b0, 8'd20, "enq20");
    step(1'b1, 1'b0, 8'd30, "enq30");
    step(1'b0, 1'b1, 8'h00, "deq_a");
    check("deq_a.value", 32'(data_out), 32'd10);
    step(1'b0, 1'b1, 8'h00, "deq_b");
    check("deq_b.value", 32'(data_out), 32'd20);

    // Interleave, with extra dequeues on empty
    step(1'b1, 1'b0, 8'd40, "enq40");
    step(1'b1, 1'b0, 8'd50, "enq50");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, "drain_hold");
    check("hold50", 32'(data_out), 32'd50);

    // Full / overflow
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i), "fill");
    check("full_after_fill", 32'(full), 32'd1);
    step(1'b1, 1'b0, 8'd99, "overflow_ignored");
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1, 8'h00, "drain_full");
      check("drain_order", 32'(data_out), 32'(i));
    end

    // Wrap and simultaneous on full
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i), "refill");
    for (int i = 9; i <= 12; i++) begin
      step(1'b1, 1'b1, 8'(i), "simul_full");
      check("simul_full.value", 32'(data_out), 32'(i - 8));
    end
    for (int i = 5; i <= 12; i++) begin
      step(1'b0, 1'b1, 8'h00, "drain_wrap");
      check("wrap_order", 32'(data_out), 32'(i));
    end
    // Simultaneous on empty: write only, no fall-through
    step(1'b1, 1'b1, 8'd77, "simul_empty");

    // Async reset with entries queued and nonzero data_out
    step(1'b1, 1'b0, 8'd81, "pre_rst_a");
    step(1'b0, 1'b1, 8'h00, "pre_rst_b");
    step(1'b1, 1'b0, 8'd82, "pre_rst_c");
    step(1'b1, 1'b0, 8'd83, "pre_rst_d");
    enqueue = 1'b0;
    dequeue = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_q.delete();
    exp_out = '0;
    check_all("async_reset");
    #1;
    reset = 1'b0;
    step(1'b0, 1'b1, 8'h00, "deq_after_async_reset");

    // Random traffic in phases biased toward filling and draining
    for (int ph = 0; ph < 12; ph++) begin
      int p_enq;
      p_enq = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 15 : 50;
      for (int i = 0; i < 150; i++) begin
        step(($urandom_range(99) < p_enq), ($urandom_range(99) < (100 - p_enq)),
             8'($urandom), "random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
